// File: rtl/mdu_pkg.sv
// ============================================================================
// Module   : mdu_pkg
// Brief    : Shared widths, iteration count, op encoding and FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam int XLEN = 32;
    localparam int ITER = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mdu_sign_fix.sv
// ============================================================================
// Module   : mdu_sign_fix
// Brief    : Conditional two's-complement negation (magnitude / sign restore).
// Revision : 1.0
// ============================================================================
`default_nettype none

module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_negate,
    output logic [WIDTH-1:0] o_result
);

    assign o_result = i_negate ? -i_value : i_value;

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module   : mul_div_unit
// Brief    : Iterative radix-2 32-bit multiply/divide producing HI/LO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             mul0_div1_sel,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] outH,
    output logic [WIDTH-1:0] outL
);

    localparam int                 c_CNT_W = $clog2(ITER);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(ITER - 1);

    state_t               r_state;
    state_t               w_stateNext;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_isDiv;
    logic                 r_negL;
    logic                 r_negH;
    logic                 r_divZero;
    logic [WIDTH-1:0]     r_origA;
    logic [WIDTH-1:0]     r_opnd;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_outH;
    logic [WIDTH-1:0]     r_outL;
    logic                 r_done;

    logic                 w_capture;
    logic                 w_step;
    logic                 w_finish;
    logic                 w_signA;
    logic                 w_signB;
    logic [WIDTH-1:0]     w_magA;
    logic [WIDTH-1:0]     w_magB;
    logic [WIDTH:0]       w_mulSum;
    logic [2*WIDTH-1:0]   w_mulNext;
    logic [WIDTH:0]       w_divTrial;
    logic                 w_divGe;
    logic [WIDTH-1:0]     w_divDiff;
    logic [2*WIDTH-1:0]   w_divNext;
    logic [2*WIDTH-1:0]   w_prodFix;
    logic [WIDTH-1:0]     w_quoFix;
    logic [WIDTH-1:0]     w_remFix;

    assign w_signA = is_signed & inA[WIDTH-1];
    assign w_signB = is_signed & inB[WIDTH-1];

    mdu_sign_fix #(.WIDTH(WIDTH)) u_magA (
        .i_value  (inA),
        .i_negate (w_signA),
        .o_result (w_magA)
    );

    mdu_sign_fix #(.WIDTH(WIDTH)) u_magB (
        .i_value  (inB),
        .i_negate (w_signB),
        .o_result (w_magB)
    );

    mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fixProd (
        .i_value  (r_acc),
        .i_negate (r_negL),
        .o_result (w_prodFix)
    );

    mdu_sign_fix #(.WIDTH(WIDTH)) u_fixQuo (
        .i_value  (r_acc[WIDTH-1:0]),
        .i_negate (r_negL),
        .o_result (w_quoFix)
    );

    mdu_sign_fix #(.WIDTH(WIDTH)) u_fixRem (
        .i_value  (r_acc[2*WIDTH-1:WIDTH]),
        .i_negate (r_negH),
        .o_result (w_remFix)
    );

    // Multiply: acc = {partial product, remaining multiplier bits}, shift right.
    assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + {1'b0, (r_acc[0] ? r_opnd : {WIDTH{1'b0}})};
    assign w_mulNext = {w_mulSum, r_acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient}, shift left.
    assign w_divTrial = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_divGe    = (w_divTrial >= {1'b0, r_opnd});
    assign w_divDiff  = w_divTrial[WIDTH-1:0] - r_opnd;
    assign w_divNext  = {(w_divGe ? w_divDiff : w_divTrial[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_divGe};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_capture   = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_capture   = 1'b1;
                    w_stateNext = CALC;
                end
            end
            CALC: begin
                w_step = 1'b1;
                if (r_count == c_LAST) begin
                    w_stateNext = FIXUP;
                end
            end
            FIXUP: begin
                w_finish    = 1'b1;
                w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_isDiv   <= 1'b0;
            r_negL    <= 1'b0;
            r_negH    <= 1'b0;
            r_divZero <= 1'b0;
            r_origA   <= '0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_outH    <= '0;
            r_outL    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_capture) begin
                r_count   <= '0;
                r_isDiv   <= mul0_div1_sel;
                r_origA   <= inA;
                r_divZero <= (inB == '0);
                r_negL    <= w_signA ^ w_signB;
                r_negH    <= w_signA;
                if (mul0_div1_sel == OP_DIV) begin
                    r_opnd <= w_magB;
                    r_acc  <= {{WIDTH{1'b0}}, w_magA};
                end else begin
                    r_opnd <= w_magA;
                    r_acc  <= {{WIDTH{1'b0}}, w_magB};
                end
            end
            if (w_step) begin
                r_count <= r_count + c_CNT_W'(1);
                r_acc   <= r_isDiv ? w_divNext : w_mulNext;
            end
            if (w_finish) begin
                // Divide by zero reports the dividend exactly as it arrived.
                if (r_isDiv && r_divZero) begin
                    r_outH <= r_origA;
                    r_outL <= '1;
                end else if (r_isDiv) begin
                    r_outH <= w_remFix;
                    r_outL <= w_quoFix;
                end else begin
                    {r_outH, r_outL} <= w_prodFix;
                end
            end
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign outH = r_outH;
    assign outL = r_outL;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module   : tb_mul_div_unit
// Brief    : Scoreboard bench for mul_div_unit (latency, arithmetic, control).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] inA;
    logic [31:0] inB;
    logic        mul0_div1_sel;
    logic        is_signed;
    logic        busy;
    logic        done;
    logic [31:0] outH;
    logic [31:0] outL;

    typedef struct {
        logic [31:0] h;
        logic [31:0] l;
    } res_t;

    res_t sbq[$];
    int   nCompared   = 0;
    int   nMismatched = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .inA           (inA),
        .inB           (inB),
        .mul0_div1_sel (mul0_div1_sel),
        .is_signed     (is_signed),
        .busy          (busy),
        .done          (done),
        .outH          (outH),
        .outL          (outL)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic div, input logic sgn);
        res_t               r;
        logic [63:0]        ea;
        logic [63:0]        eb;
        logic [63:0]        p;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic signed [63:0] m;
        ea = sgn ? {{32{a[31]}}, a} : {32'h0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'h0, b};
        if (!div) begin
            p   = ea * eb;
            r.h = p[63:32];
            r.l = p[31:0];
        end else if (b == 32'h0) begin
            r.h = a;
            r.l = 32'hFFFF_FFFF;
        end else if (sgn) begin
            sa  = ea;
            sb  = eb;
            q   = sa / sb;
            m   = sa % sb;
            r.h = m[31:0];
            r.l = q[31:0];
        end else begin
            r.h = a % b;
            r.l = a / b;
        end
        return r;
    endfunction

    // Called one time unit after a rising edge; the next edge is the start edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic div, input logic sgn);
        inA           = a;
        inB           = b;
        mul0_div1_sel = div;
        is_signed     = sgn;
        start         = 1'b1;
        sbq.push_back(model(a, b, div, sgn));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output int busyCnt);
        cycles  = 0;
        busyCnt = (busy === 1'b1) ? 1 : 0;
        while (cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (busy === 1'b1) busyCnt++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; inA = '0; inB = '0;
        mul0_div1_sel = 1'b0; is_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nCompared += 4;
        if (busy !== 1'b0) begin nMismatched++; $display("FAIL reset busy: got %b want 0", busy); end
        if (done !== 1'b0) begin nMismatched++; $display("FAIL reset done: got %b want 0", done); end
        if (outH !== 32'h0) begin nMismatched++; $display("FAIL reset outH: got %h want 0", outH); end
        if (outL !== 32'h0) begin nMismatched++; $display("FAIL reset outL: got %h want 0", outL); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_arith(input string tag, input logic [31:0] va[],
                              input logic [31:0] vb[], input logic vd[], input logic vs[]);
        int   cyc;
        int   bc;
        res_t e;
        for (int i = 0; i < va.size(); i++) begin
            issue(va[i], vb[i], vd[i], vs[i]);
            wait_done(cyc, bc);
            e = sbq.pop_front();
            nCompared += 4;
            if (cyc !== 33) begin nMismatched++; $display("FAIL %s[%0d] latency: got %0d want 33", tag, i, cyc); end
            if (bc !== 33) begin nMismatched++; $display("FAIL %s[%0d] busy cycles: got %0d want 33", tag, i, bc); end
            if (outH !== e.h) begin nMismatched++; $display("FAIL %s[%0d] outH: got %h want %h", tag, i, outH, e.h); end
            if (outL !== e.l) begin nMismatched++; $display("FAIL %s[%0d] outL: got %h want %h", tag, i, outL, e.l); end
            @(posedge clk);
            #1;
            nCompared += 3;
            if (done !== 1'b0) begin nMismatched++; $display("FAIL %s[%0d] done pulse width: got %b want 0", tag, i, done); end
            if (outH !== e.h) begin nMismatched++; $display("FAIL %s[%0d] held outH: got %h want %h", tag, i, outH, e.h); end
            if (outL !== e.l) begin nMismatched++; $display("FAIL %s[%0d] held outL: got %h want %h", tag, i, outL, e.l); end
        end
    endtask

    task automatic test_mul();
        logic [31:0] va[] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF9};
        logic [31:0] vb[] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd6};
        logic        vd[] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        vs[] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        test_arith("mul", va, vb, vd, vs);
    endtask

    task automatic test_div();
        logic [31:0] va[] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FFF9};
        logic [31:0] vb[] = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd2};
        logic        vd[] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        vs[] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        test_arith("div", va, vb, vd, vs);
    endtask

    task automatic test_div_zero();
        logic [31:0] va[] = '{32'h1234_5678, 32'h1234_5678, 32'h8000_0001};
        logic [31:0] vb[] = '{32'h0, 32'h0, 32'h0};
        logic        vd[] = '{1'b1, 1'b1, 1'b1};
        logic        vs[] = '{1'b1, 1'b0, 1'b1};
        test_arith("divzero", va, vb, vd, vs);
    endtask

    task automatic test_random();
        logic [31:0] va[];
        logic [31:0] vb[];
        logic        vd[];
        logic        vs[];
        va = new[10]; vb = new[10]; vd = new[10]; vs = new[10];
        for (int i = 0; i < 10; i++) begin
            va[i] = $urandom;
            vb[i] = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            vd[i] = 1'($urandom_range(0, 1));
            vs[i] = 1'($urandom_range(0, 1));
        end
        test_arith("rand", va, vb, vd, vs);
    endtask

    task automatic test_ignore_start();
        int   cyc;
        int   bc;
        res_t e;
        issue(32'd7, 32'd6, 1'b0, 1'b1);
        repeat (9) begin @(posedge clk); #1; end
        inA = 32'd3; inB = 32'd3; mul0_div1_sel = 1'b1; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, bc);
        e = sbq.pop_front();
        nCompared += 3;
        if (cyc + 10 !== 33) begin nMismatched++; $display("FAIL ignore_start latency: got %0d want 33", cyc + 10); end
        if (outH !== e.h) begin nMismatched++; $display("FAIL ignore_start outH: got %h want %h", outH, e.h); end
        if (outL !== e.l) begin nMismatched++; $display("FAIL ignore_start outL: got %h want %h", outL, e.l); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        res_t e;
        bit   sawDone;
        bit   sawBusy;
        issue(32'h0001_2345, 32'h77, 1'b1, 1'b0);
        repeat (14) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        e = sbq.pop_front();
        nCompared += 4;
        if (busy !== 1'b0) begin nMismatched++; $display("FAIL reset_mid busy: got %b want 0", busy); end
        if (done !== 1'b0) begin nMismatched++; $display("FAIL reset_mid done: got %b want 0", done); end
        if (outH !== 32'h0) begin nMismatched++; $display("FAIL reset_mid outH: got %h want 0 (aborted %h)", outH, e.h); end
        if (outL !== 32'h0) begin nMismatched++; $display("FAIL reset_mid outL: got %h want 0 (aborted %h)", outL, e.l); end
        sawDone = 1'b0;
        sawBusy = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) sawDone = 1'b1;
            if (busy !== 1'b0) sawBusy = 1'b1;
        end
        nCompared += 2;
        if (sawDone) begin nMismatched++; $display("FAIL reset_mid late done: got 1 want 0"); end
        if (sawBusy) begin nMismatched++; $display("FAIL reset_mid late busy: got 1 want 0"); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va[3] = '{32'd100, 32'hFFFF_FFF9, 32'h0000_FFFF};
        logic [31:0] vb[3] = '{32'd7, 32'd3, 32'h0001_0001};
        logic        vd[3] = '{1'b1, 1'b0, 1'b0};
        logic        vs[3] = '{1'b0, 1'b1, 1'b0};
        int          cyc;
        int          bc;
        bit          held;
        res_t        prev;
        res_t        e;
        issue(va[0], vb[0], vd[0], vs[0]);
        wait_done(cyc, bc);
        prev = sbq.pop_front();
        nCompared += 2;
        if (outH !== prev.h) begin nMismatched++; $display("FAIL b2b[0] outH: got %h want %h", outH, prev.h); end
        if (outL !== prev.l) begin nMismatched++; $display("FAIL b2b[0] outL: got %h want %h", outL, prev.l); end
        for (int k = 1; k < 3; k++) begin
            issue(va[k], vb[k], vd[k], vs[k]);
            held = 1'b1;
            cyc  = 0;
            while (cyc < 40) begin
                @(posedge clk);
                #1;
                cyc++;
                if (done === 1'b1) break;
                if (outH !== prev.h || outL !== prev.l) held = 1'b0;
            end
            e = sbq.pop_front();
            nCompared += 4;
            if (!held) begin nMismatched++; $display("FAIL b2b[%0d] previous result held: got changed want %h_%h", k, prev.h, prev.l); end
            if (cyc !== 33) begin nMismatched++; $display("FAIL b2b[%0d] latency: got %0d want 33", k, cyc); end
            if (outH !== e.h) begin nMismatched++; $display("FAIL b2b[%0d] outH: got %h want %h", k, outH, e.h); end
            if (outL !== e.l) begin nMismatched++; $display("FAIL b2b[%0d] outL: got %h want %h", k, outL, e.l); end
            prev = e;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
